// File: rtl/minirisc_control_fsm_pkg.sv
// Shared encodings for the miniRISC main control unit: opcodes, functs,
// FSM states and the datapath control bundle with its per-state views.
package minirisc_control_fsm_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [5:0] OP_RALU   = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b000001;
    localparam logic [5:0] OP_COMPI  = 6'b000010;
    localparam logic [5:0] OP_RSHIFT = 6'b000011;
    localparam logic [5:0] OP_LW     = 6'b001000;
    localparam logic [5:0] OP_SW     = 6'b001001;
    localparam logic [5:0] OP_BR     = 6'b010000;
    localparam logic [5:0] OP_BLTZ   = 6'b010001;
    localparam logic [5:0] OP_BZ     = 6'b010010;
    localparam logic [5:0] OP_BNZ    = 6'b010011;
    localparam logic [5:0] OP_BREG   = 6'b010100;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    localparam logic [4:0] FN_ADD  = 5'b00000;
    localparam logic [4:0] FN_COMP = 5'b00001;
    localparam logic [4:0] FN_AND  = 5'b00010;
    localparam logic [4:0] FN_XOR  = 5'b00011;

    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;
    localparam logic [1:0] RD_RD   = 2'b00;
    localparam logic [1:0] RD_RT   = 2'b01;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] JT_LONG = 2'b01;
    localparam logic [1:0] JT_REG  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       imm_sel;
        logic       alu_src;
        logic       comp_enbl;
        logic       shift_amnt_sel;
        logic       shift_enbl;
        logic       short_br;
        logic       long_br;
        logic       mem_read;
        logic       mem_write;
        logic       branch_reg;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] shift_type;
        logic [1:0] branch_type;
        logic [1:0] jump_type;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Memory strobes are only ever driven from MEM, never from EXEC.
    function automatic ctrl_t exec_view(ctrl_t c);
        ctrl_t v = c;
        v.mem_read  = 1'b0;
        v.mem_write = 1'b0;
        return v;
    endfunction

    function automatic ctrl_t mem_view(ctrl_t c);
        ctrl_t v = c;
        v.reg_write = 1'b0;
        return v;
    endfunction

    function automatic ctrl_t wb_view();
        ctrl_t v = CTRL_NONE;
        v.reg_write  = 1'b1;
        v.reg_dst    = RD_RT;
        v.mem_to_reg = M2R_MEM;
        return v;
    endfunction

endpackage

// File: rtl/minirisc_control_fsm_decode.sv
// Combinational opcode/funct decode into the control bundle plus legality.
module minirisc_control_fsm_decode
    import minirisc_control_fsm_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] funct,
    output ctrl_t      ctrl,
    output logic       legal,
    output logic       is_halt
);

    always_comb begin
        ctrl    = CTRL_NONE;
        legal   = 1'b1;
        is_halt = 1'b0;
        case (opcode)
            OP_RALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = RD_RD;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_COMP: begin
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.comp_enbl = 1'b1;
                    end
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_COMPI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.reg_write = 1'b1;
                ctrl.comp_enbl = (opcode == OP_COMPI);
            end
            OP_RSHIFT: begin
                ctrl.shift_enbl     = 1'b1;
                ctrl.reg_write      = 1'b1;
                ctrl.shift_type     = funct[1:0];
                ctrl.shift_amnt_sel = funct[2];
                // Only the low three funct bits carry meaning for shifts.
                legal = (funct[4:3] == 2'b00);
            end
            OP_LW, OP_SW: begin
                ctrl.imm_sel   = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.mem_write = (opcode == OP_SW);
                ctrl.mem_read  = (opcode == OP_LW);
                if (opcode == OP_LW) begin
                    ctrl.reg_dst    = RD_RT;
                    ctrl.mem_to_reg = M2R_MEM;
                end
            end
            OP_BR: begin
                ctrl.long_br   = 1'b1;
                ctrl.jump_type = JT_LONG;
            end
            OP_BLTZ, OP_BZ, OP_BNZ: begin
                ctrl.short_br    = 1'b1;
                ctrl.branch_type = opcode[1:0];
            end
            OP_BREG: begin
                ctrl.branch_reg = 1'b1;
                ctrl.jump_type  = JT_REG;
            end
            OP_HALT: is_halt = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/minirisc_control_fsm.sv
// Multi-cycle main control FSM: FETCH(wait imem) | DECODE(latch) | EXEC(1 cyc)
// | MEM(wait dmem) | WB(lw) | HALT/ERR(absorbing). Outputs are registered.
module minirisc_control_fsm
    import minirisc_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [4:0] funct,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       ir_load,
    output logic       pc_write,
    output logic       RegWrite,
    output logic       ImmSel,
    output logic       ALUSrc,
    output logic       CompEnbl,
    output logic       ShiftAmntSel,
    output logic       ShiftEnbl,
    output logic       ShortBr,
    output logic       LongBr,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       BranchReg,
    output logic [1:0] ALUOp,
    output logic [1:0] RegDst,
    output logic [1:0] ShiftType,
    output logic [1:0] BranchType,
    output logic [1:0] JumpType,
    output logic [1:0] MemToReg,
    output logic       halted,
    output logic       err,
    output logic [2:0] state_dbg
);

    state_t          state;
    ctrl_t           dec_q;
    ctrl_t           out_q;
    ctrl_t           dec_c;
    logic            legal_c;
    logic            halt_c;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W:0]   cnt_inc;
    logic            timeout_hit;

    minirisc_control_fsm_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .ctrl    (dec_c),
        .legal   (legal_c),
        .is_halt (halt_c)
    );

    // The current waiting cycle is the MEM_TIMEOUT-th one without ready.
    assign cnt_inc     = {1'b0, to_cnt} + {{TO_W{1'b0}}, 1'b1};
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == (TO_W+1)'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            dec_q    <= CTRL_NONE;
            out_q    <= CTRL_NONE;
            to_cnt   <= '0;
            ir_load  <= 1'b0;
            pc_write <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            out_q    <= CTRL_NONE;
            ir_load  <= 1'b0;
            pc_write <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        to_cnt <= '0;
                        state  <= S_DECODE;
                    end else if (timeout_hit) begin
                        to_cnt <= '0;
                        err    <= 1'b1;
                        state  <= S_ERR;
                    end else begin
                        to_cnt  <= cnt_inc[TO_W-1:0];
                        ir_load <= 1'b1;
                    end
                end
                S_DECODE: begin
                    dec_q <= dec_c;
                    if (!legal_c) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else if (halt_c) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        out_q    <= exec_view(dec_c);
                        pc_write <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dec_q.mem_read || dec_q.mem_write) begin
                        out_q <= mem_view(dec_q);
                        state <= S_MEM;
                    end else begin
                        ir_load <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        to_cnt <= '0;
                        if (dec_q.mem_read) begin
                            out_q <= wb_view();
                            state <= S_WB;
                        end else begin
                            ir_load <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end else if (timeout_hit) begin
                        to_cnt <= '0;
                        err    <= 1'b1;
                        state  <= S_ERR;
                    end else begin
                        to_cnt <= cnt_inc[TO_W-1:0];
                        out_q  <= mem_view(dec_q);
                    end
                end
                S_WB: begin
                    ir_load <= 1'b1;
                    state   <= S_FETCH;
                end
                S_HALT, S_ERR: state <= state;
                default: begin
                    err   <= 1'b1;
                    state <= S_ERR;
                end
            endcase
        end
    end

    assign RegWrite     = out_q.reg_write;
    assign ImmSel       = out_q.imm_sel;
    assign ALUSrc       = out_q.alu_src;
    assign CompEnbl     = out_q.comp_enbl;
    assign ShiftAmntSel = out_q.shift_amnt_sel;
    assign ShiftEnbl    = out_q.shift_enbl;
    assign ShortBr      = out_q.short_br;
    assign LongBr       = out_q.long_br;
    assign MemRead      = out_q.mem_read;
    assign MemWrite     = out_q.mem_write;
    assign BranchReg    = out_q.branch_reg;
    assign ALUOp        = out_q.alu_op;
    assign RegDst       = out_q.reg_dst;
    assign ShiftType    = out_q.shift_type;
    assign BranchType   = out_q.branch_type;
    assign JumpType     = out_q.jump_type;
    assign MemToReg     = out_q.mem_to_reg;
    assign state_dbg    = state;

endmodule

// File: tb/tb_minirisc_control_fsm.sv
// Bench for the miniRISC control FSM: per-instruction expected cycle traces
// built from the class table, applied as {inputs, expected} vectors.
module tb_minirisc_control_fsm;

    localparam int TO = 15;
    localparam int K_ILL = 0, K_ALU = 1, K_BR = 2, K_LW = 3, K_SW = 4, K_HALT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [4:0] funct = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       ir_load, pc_write, RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel;
    logic       ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg, halted, err;
    logic [1:0] ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    minirisc_control_fsm #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .ir_load(ir_load), .pc_write(pc_write), .RegWrite(RegWrite), .ImmSel(ImmSel),
        .ALUSrc(ALUSrc), .CompEnbl(CompEnbl), .ShiftAmntSel(ShiftAmntSel),
        .ShiftEnbl(ShiftEnbl), .ShortBr(ShortBr), .LongBr(LongBr), .MemRead(MemRead),
        .MemWrite(MemWrite), .BranchReg(BranchReg), .ALUOp(ALUOp), .RegDst(RegDst),
        .ShiftType(ShiftType), .BranchType(BranchType), .JumpType(JumpType),
        .MemToReg(MemToReg), .halted(halted), .err(err), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [2:0] st;
        logic ir, pcw, rw, imm, alusrc, comp, sas, sen, sbr, lbr, mr, mw, breg;
        logic [1:0] aluop, rdst, stype, btype, jtype, m2r;
        logic hlt, er;
    } obs_t;

    typedef struct {
        int         tag;
        logic       imem;
        logic       dmem;
        logic [5:0] op;
        logic [4:0] fn;
        obs_t       exp;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic [4:0] fn;
        int         f;
        int         m;
    } dir_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   instr_id = 0;
    bit   first_fetch = 1'b1;

    function automatic obs_t sample();
        obs_t o;
        o.st = state_dbg; o.ir = ir_load; o.pcw = pc_write; o.rw = RegWrite;
        o.imm = ImmSel; o.alusrc = ALUSrc; o.comp = CompEnbl; o.sas = ShiftAmntSel;
        o.sen = ShiftEnbl; o.sbr = ShortBr; o.lbr = LongBr; o.mr = MemRead;
        o.mw = MemWrite; o.breg = BranchReg; o.aluop = ALUOp; o.rdst = RegDst;
        o.stype = ShiftType; o.btype = BranchType; o.jtype = JumpType;
        o.m2r = MemToReg; o.hlt = halted; o.er = err;
        return o;
    endfunction

    // Reference class table: controls each opcode/funct asks for.
    function automatic obs_t class_ctrl(input logic [5:0] op, input logic [4:0] fn,
                                        output int kind);
        obs_t c = '0;
        kind = K_ILL;
        case (op)
            6'b000000: if (fn <= 5'd3) begin
                kind = K_ALU; c.rw = 1'b1;
                c.aluop = (fn == 5'd2) ? 2'b10 : (fn == 5'd3) ? 2'b11 : 2'b01;
                c.comp = (fn == 5'd1);
            end
            6'b000001, 6'b000010: begin
                kind = K_ALU; c.rw = 1'b1; c.alusrc = 1'b1; c.aluop = 2'b01;
                c.comp = (op == 6'b000010);
            end
            6'b000011: if (fn[4:3] == 2'b00) begin
                kind = K_ALU; c.rw = 1'b1; c.sen = 1'b1;
                c.stype = fn[1:0]; c.sas = fn[2];
            end
            6'b001000: begin
                kind = K_LW; c.imm = 1'b1; c.alusrc = 1'b1; c.aluop = 2'b01;
                c.rdst = 2'b01; c.mr = 1'b1; c.m2r = 2'b01;
            end
            6'b001001: begin
                kind = K_SW; c.imm = 1'b1; c.alusrc = 1'b1; c.aluop = 2'b01; c.mw = 1'b1;
            end
            6'b010000: begin kind = K_BR; c.lbr = 1'b1; c.jtype = 2'b01; end
            6'b010001, 6'b010010, 6'b010011: begin
                kind = K_BR; c.sbr = 1'b1; c.btype = op[1:0];
            end
            6'b010100: begin kind = K_BR; c.breg = 1'b1; c.jtype = 2'b10; end
            6'b111111: kind = K_HALT;
            default: kind = K_ILL;
        endcase
        return c;
    endfunction

    task automatic push(input logic im, input logic dm, input logic [5:0] op,
                        input logic [4:0] fn, input obs_t e);
        vec_t v;
        v.tag = instr_id; v.imem = im; v.dmem = dm; v.op = op; v.fn = fn; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic push_terminal(input bit is_err);
        obs_t e;
        for (int i = 0; i < 4; i++) begin
            e = '0;
            e.st = is_err ? 3'd6 : 3'd5;
            e.er = is_err;
            e.hlt = !is_err;
            push(1'($urandom), 1'($urandom), 6'($urandom), 5'($urandom), e);
        end
    endtask

    // Expected cycle trace of one instruction: f not-ready fetch cycles, m not-ready mem cycles.
    task automatic add_instr(input logic [5:0] op, input logic [4:0] fn, input int f, input int m);
        obs_t c, e;
        int kind;
        c = class_ctrl(op, fn, kind);
        for (int i = 0; i <= f && i < TO; i++) begin
            e = '0;
            e.ir = !(i == 0 && first_fetch);
            push(i == f, 1'($urandom), 6'($urandom), 5'($urandom), e);
        end
        first_fetch = 1'b0;
        if (f >= TO) begin push_terminal(1'b1); instr_id++; return; end
        e = '0; e.st = 3'd1;
        push(1'($urandom), 1'($urandom), op, fn, e);
        if (kind == K_ILL || kind == K_HALT) begin
            push_terminal(kind == K_ILL); instr_id++; return;
        end
        e = c; e.mr = 1'b0; e.mw = 1'b0; e.pcw = 1'b1; e.st = 3'd2;
        push(1'($urandom), 1'($urandom), 6'($urandom), 5'($urandom), e);
        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i <= m && i < TO; i++) begin
                e = c; e.st = 3'd3;
                push(1'($urandom), i == m, 6'($urandom), 5'($urandom), e);
            end
            if (m >= TO) begin push_terminal(1'b1); instr_id++; return; end
            if (kind == K_LW) begin
                e = '0; e.st = 3'd4; e.rw = 1'b1; e.rdst = 2'b01; e.m2r = 2'b01;
                push(1'($urandom), 1'($urandom), 6'($urandom), 5'($urandom), e);
            end
        end
        instr_id++;
    endtask

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_vectors();
        for (int i = 0; i < vq.size(); i++) begin
            check($sformatf("vec%0d_instr%0d", i, vq[i].tag), vq[i].exp);
            imem_ready = vq[i].imem;
            dmem_ready = vq[i].dmem;
            opcode     = vq[i].op;
            funct      = vq[i].fn;
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check(name, obs_t'(0));
        first_fetch = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_t dtab[15];
        logic [5:0] legal_ops[11];
        obs_t e;
        logic [5:0] rop;
        logic [4:0] rfn;

        dtab[0]  = '{6'b000001, 5'd0,  0, 0};   // addi, imem ready immediately
        dtab[1]  = '{6'b001000, 5'd0,  1, 3};   // lw, dmem delayed 3 cycles
        dtab[2]  = '{6'b000000, 5'd3,  0, 0};   // xor
        dtab[3]  = '{6'b000000, 5'd1,  2, 0};   // comp
        dtab[4]  = '{6'b000000, 5'd0,  0, 0};   // add
        dtab[5]  = '{6'b000000, 5'd2,  0, 0};   // and
        dtab[6]  = '{6'b000010, 5'd9,  0, 0};   // compi
        dtab[7]  = '{6'b000011, 5'd5,  1, 0};   // shift, amount-sel set
        dtab[8]  = '{6'b001001, 5'd0,  0, 0};   // sw, dmem ready at once
        dtab[9]  = '{6'b010000, 5'd0,  0, 0};   // br
        dtab[10] = '{6'b010001, 5'd0,  0, 0};   // bltz
        dtab[11] = '{6'b010010, 5'd0,  0, 0};   // bz
        dtab[12] = '{6'b010011, 5'd0,  0, 0};   // bnz
        dtab[13] = '{6'b010100, 5'd0,  0, 0};   // br-reg
        dtab[14] = '{6'b001000, 5'd0,  0, 0};   // lw, dmem ready at once

        legal_ops = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b001000, 6'b001001,
                      6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b010100};

        do_reset("reset_state");
        foreach (dtab[i]) add_instr(dtab[i].op, dtab[i].fn, dtab[i].f, dtab[i].m);
        run_vectors();

        for (int i = 0; i < 40; i++) begin
            rop = legal_ops[$urandom_range(0, 10)];
            if (rop == 6'b000000)      rfn = 5'($urandom_range(0, 3));
            else if (rop == 6'b000011) rfn = 5'($urandom_range(0, 7));
            else                       rfn = 5'($urandom);
            add_instr(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_vectors();

        // Reset while an sw waits in MEM: no write strobe may survive the reset.
        do_reset("reset_before_sw");
        add_instr(6'b001001, 5'd0, 0, 5);
        while (vq.size() > 5) void'(vq.pop_back());
        run_vectors();
        e = '0; e.st = 3'd3; e.imm = 1'b1; e.alusrc = 1'b1; e.aluop = 2'b01; e.mw = 1'b1;
        check("sw_mem_before_reset", e);
        do_reset("reset_mid_mem");
        add_instr(6'b000001, 5'd0, 0, 0);
        run_vectors();

        do_reset("reset_before_illegal_op");
        add_instr(6'b101010, 5'd0, 0, 0);
        run_vectors();
        do_reset("reset_clears_err");
        add_instr(6'b000000, 5'd4, 0, 0);
        run_vectors();

        do_reset("reset_before_timeout");
        add_instr(6'b001001, 5'd0, 0, TO - 1);
        add_instr(6'b001001, 5'd0, 0, TO);
        run_vectors();
        do_reset("reset_before_fetch_timeout");
        add_instr(6'b000001, 5'd0, TO, 0);
        run_vectors();

        do_reset("reset_before_halt");
        add_instr(6'b111111, 5'd0, 1, 0);
        run_vectors();
        do_reset("reset_after_halt");
        add_instr(6'b001000, 5'd0, 0, 2);
        add_instr(6'b000001, 5'd0, 0, 0);
        run_vectors();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/minirisc_control_fsm.md
Name: miniRISC_control_fsm

Overview:
Multi-cycle main control unit for the KGP miniRISC datapath. It decodes the 6-bit opcode and 5-bit funct of the fetched instruction and drives the control bundle that CPU_TOP_MODULE consumes (RegWrite, ALUSrc, MemToReg, ...). It sequences fetch, decode, execute, memory and writeback, and waits on instruction- and data-memory ready handshakes. It replaces manual per-cycle driving of the control bundle.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for imem_ready/dmem_ready before raising err (0 = wait forever)
TO_W, 4, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  instruction[31:26], sampled only in DECODE
funct  in  5  instruction[4:0], sampled only in DECODE
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data memory access complete this cycle
ir_load  out  1  load instruction register
pc_write  out  1  commit next PC (sequential or branch target)
RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg  out  1 each  datapath controls
ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg  out  2 each  datapath controls
halted  out  1  HALT state reached
err  out  1  sticky: illegal opcode/funct or memory timeout
state_dbg  out  3  current state encoding

Behaviour:
- Clock clk, reset rst: synchronous, active-high. On reset: state=FETCH, every output 0, err=0, timeout counter=0. Reset in any state (including mid-MEM) aborts the instruction with no RegWrite/MemWrite pulse in the reset cycle.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- FETCH: ir_load=1 while imem_ready=0. When imem_ready=1 -> DECODE.
- DECODE: register {opcode,funct} into the latched decode. Illegal -> ERR. opcode 111111 (halt) -> HALT. Otherwise -> EXEC.
- Class table (opcode -> controls), with all unlisted outputs 0:
  000000 R-ALU: ALUSrc=0, RegDst=00, RegWrite=1. funct 00000 add ALUOp=01. 00001 comp ALUOp=01, CompEnbl=1. 00010 and ALUOp=10. 00011 xor ALUOp=11.
  000001 addi: ALUSrc=1, ALUOp=01, RegWrite=1.
  000010 compi: as addi plus CompEnbl=1.
  000011 R-shift: ShiftEnbl=1, RegWrite=1, ShiftType=funct[1:0], ShiftAmntSel=funct[2].
  001000 lw: ImmSel=1, ALUSrc=1, ALUOp=01, RegDst=01, MemRead=1, MemToReg=01.
  001001 sw: ImmSel=1, ALUSrc=1, ALUOp=01, MemWrite=1.
  010000 br: LongBr=1, JumpType=01. 010001..010011 bltz/bz/bnz: ShortBr=1, BranchType=opcode[1:0]. 010100 br-reg: BranchReg=1, JumpType=10.
- EXEC (1 cycle): the class controls are driven. pc_write=1 for all classes. RegWrite is pulsed here only for ALU/shift classes. lw/sw -> MEM, all others -> FETCH.
- MEM: MemRead or MemWrite held stable with address controls until dmem_ready=1. Then lw -> WB, sw -> FETCH. MemWrite is never asserted outside MEM.
- WB (lw only, 1 cycle): RegWrite=1, RegDst=01, MemToReg=01.
- Invariant: exactly one RegWrite cycle per writing instruction and none otherwise.
- Timeout: a counter increments per waiting cycle in FETCH/MEM and clears on ready. If the counter equals MEM_TIMEOUT and MEM_TIMEOUT≠0 -> ERR.
- HALT/ERR: absorbing until rst. All controls 0. halted=1 in HALT. err=1 in ERR.
- Simultaneous ready and timeout in the same cycle: ready wins.

Decomposition:
- Package miniRISC_pkg: opcode/funct localparams, state encodings, ALUOp/RegDst/MemToReg codes.
- Sub-module miniRISC_decode: combinational {opcode,funct} -> control bundle plus legal flag. The FSM registers the decode and gates outputs per state.

Test Plan:
- Reset mid-MEM of sw (dmem_ready=0) -> MemWrite=0 in the next cycle, state=FETCH, no RegWrite.
- addi (000001), imem_ready at first FETCH cycle -> FETCH,DECODE,EXEC. In EXEC: RegWrite=1, ALUSrc=1, ALUOp=01, pc_write=1. Back in FETCH on cycle 4.
- lw with dmem_ready delayed 3 cycles -> MemRead=1, MemToReg=01 for 4 MEM cycles. Then exactly one WB cycle with RegWrite=1, RegDst=01.
- R-type funct 00011 (xor) -> ALUOp=11, CompEnbl=0. funct 00001 (comp) -> CompEnbl=1, ALUOp=01.
- Opcode 101010 -> ERR after DECODE, err=1 sticky, all controls 0 until rst.
- MEM_TIMEOUT=15, dmem_ready never asserted on sw -> ERR entered after 15 MEM cycles. dmem_ready arriving at cycle 15 -> completes normally.
